// File: rtl/rv_alu_pkg.sv
// Shared ALU encodings, op classes and the ID/EX control bundle
// for the execute front end.
package rv_alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    OPC_LS = 2'b00,
    OPC_BR = 2'b01,
    OPC_R  = 2'b10,
    OPC_I  = 2'b11
  } opc_e;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  typedef struct packed {
    logic [3:0] aluop;
    logic       illegal;
    logic       is_branch;
    logic       alu_src;
    logic       reg_write;
  } id_ex_t;

endpackage

// File: rtl/alu_ctrl.sv
// Combinational ALU control: op class, funct3 and bit 30 map to
// the 4-bit ALU code plus an illegal-combination flag.
module alu_ctrl
  import rv_alu_pkg::*;
(
  input  logic [1:0] i_op_class,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7_5,
  output logic [3:0] o_aluop,
  output logic       o_illegal
);

  logic w_is_r;

  assign w_is_r = (i_op_class == OPC_R);

  always_comb begin
    o_aluop   = ALU_ADD;
    o_illegal = 1'b0;
    unique case (i_op_class)
      OPC_LS: o_aluop = ALU_ADD;
      OPC_BR: o_aluop = ALU_SUB;
      default: begin
        // I-type has no SUB; bit 30 only selects it for R-type
        unique case (i_funct3)
          F3_ADD: o_aluop = (w_is_r && i_funct7_5) ? ALU_SUB : ALU_ADD;
          F3_AND: o_aluop = ALU_AND;
          F3_OR:  o_aluop = ALU_OR;
          F3_SLT: o_aluop = ALU_SLT;
          default: begin
            o_aluop   = ALU_ADD;
            o_illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshake, flush,
// operand forwarding and stall-time WB refresh.
module id_ex_stage
  import rv_alu_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [1:0]      id_op_class,
  input  logic [2:0]      id_funct3,
  input  logic            id_funct7_5,
  input  logic            id_alu_src,
  input  logic            id_reg_write,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic [REGW-1:0] id_rd,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic            mem_fwd_we,
  input  logic [REGW-1:0] mem_fwd_rd,
  input  logic [XLEN-1:0] mem_fwd_data,
  input  logic            wb_we,
  input  logic [REGW-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_in1,
  output logic [XLEN-1:0] ex_in2,
  output logic [3:0]      ex_aluop,
  output logic [REGW-1:0] ex_rd,
  output logic            ex_reg_write,
  output logic            ex_is_branch,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic            ex_illegal
);

  logic            r_valid;
  id_ex_t          r_ctrl;
  logic [REGW-1:0] r_rs1;
  logic [REGW-1:0] r_rs2;
  logic [REGW-1:0] r_rd;
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_rs2_data;
  logic [XLEN-1:0] r_imm;

  logic            w_load;
  logic            w_hold;
  logic [3:0]      w_aluop;
  logic            w_illegal;
  id_ex_t          w_ctrl_d;
  logic            w_wb_rs1;
  logic            w_wb_rs2;
  logic [XLEN-1:0] w_rs1_fwd;
  logic [XLEN-1:0] w_rs2_fwd;

  alu_ctrl u_alu_ctrl (
    .i_op_class (id_op_class),
    .i_funct3   (id_funct3),
    .i_funct7_5 (id_funct7_5),
    .o_aluop    (w_aluop),
    .o_illegal  (w_illegal)
  );

  assign id_ready = !r_valid || ex_ready;
  assign w_load   = id_valid && id_ready;
  assign w_hold   = r_valid && !ex_ready;

  always_comb begin
    w_ctrl_d           = '0;
    w_ctrl_d.aluop     = w_aluop;
    w_ctrl_d.illegal   = w_illegal;
    w_ctrl_d.is_branch = (id_op_class == OPC_BR);
    w_ctrl_d.alu_src   = id_alu_src;
    w_ctrl_d.reg_write = id_reg_write;
  end

  assign w_wb_rs1 = wb_we && (wb_rd == r_rs1) && (r_rs1 != '0);
  assign w_wb_rs2 = wb_we && (wb_rd == r_rs2) && (r_rs2 != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_ctrl     <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
    end else begin
      if (flush)
        r_valid <= 1'b0;
      else if (w_load)
        r_valid <= 1'b1;
      else if (ex_ready)
        r_valid <= 1'b0;

      if (w_load) begin
        r_ctrl     <= w_ctrl_d;
        r_rs1      <= id_rs1;
        r_rs2      <= id_rs2;
        r_rd       <= id_rd;
        r_rs1_data <= id_rs1_data;
        r_rs2_data <= id_rs2_data;
        r_imm      <= id_imm;
      end else if (w_hold) begin
        // a result retiring from WB mid-stall would otherwise be lost
        if (w_wb_rs1)
          r_rs1_data <= wb_data;
        if (w_wb_rs2)
          r_rs2_data <= wb_data;
      end
    end
  end

  function automatic logic [XLEN-1:0] fwd(
    input logic [REGW-1:0] rs,
    input logic [XLEN-1:0] val,
    input logic            m_we,
    input logic [REGW-1:0] m_rd,
    input logic [XLEN-1:0] m_d,
    input logic            w_we,
    input logic [REGW-1:0] w_rd,
    input logic [XLEN-1:0] w_d
  );
    if (rs == '0)
      return '0;
    if (m_we && (m_rd == rs))
      return m_d;
    if (w_we && (w_rd == rs))
      return w_d;
    return val;
  endfunction

  assign w_rs1_fwd = fwd(r_rs1, r_rs1_data,
                         mem_fwd_we, mem_fwd_rd, mem_fwd_data,
                         wb_we, wb_rd, wb_data);
  assign w_rs2_fwd = fwd(r_rs2, r_rs2_data,
                         mem_fwd_we, mem_fwd_rd, mem_fwd_data,
                         wb_we, wb_rd, wb_data);

  assign ex_valid     = r_valid;
  assign ex_in1       = w_rs1_fwd;
  assign ex_in2       = r_ctrl.alu_src ? r_imm : w_rs2_fwd;
  assign ex_rs2_val   = w_rs2_fwd;
  assign ex_aluop     = r_ctrl.aluop;
  assign ex_rd        = r_rd;
  assign ex_reg_write = r_ctrl.reg_write && r_valid;
  assign ex_is_branch = r_ctrl.is_branch;
  assign ex_illegal   = r_ctrl.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scoreboard bench for id_ex_stage: handshake, decode,
// forwarding, stall refresh, flush and reset.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        id_valid, id_ready;
  logic [1:0]  id_op_class;
  logic [2:0]  id_funct3;
  logic        id_funct7_5, id_alu_src, id_reg_write;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [63:0] id_rs1_data, id_rs2_data, id_imm;
  logic        mem_fwd_we;
  logic [4:0]  mem_fwd_rd;
  logic [63:0] mem_fwd_data;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        ex_valid, ex_ready;
  logic [63:0] ex_in1, ex_in2, ex_rs2_val;
  logic [3:0]  ex_aluop;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_is_branch, ex_illegal;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        vld;
    logic [3:0]  op;
    logic [63:0] in1;
    logic [63:0] in2;
    logic [63:0] rs2v;
    logic        rw;
    logic        br;
    logic        ill;
    string       tag;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .id_valid     (id_valid),
    .id_ready     (id_ready),
    .id_op_class  (id_op_class),
    .id_funct3    (id_funct3),
    .id_funct7_5  (id_funct7_5),
    .id_alu_src   (id_alu_src),
    .id_reg_write (id_reg_write),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rd        (id_rd),
    .id_rs1_data  (id_rs1_data),
    .id_rs2_data  (id_rs2_data),
    .id_imm       (id_imm),
    .mem_fwd_we   (mem_fwd_we),
    .mem_fwd_rd   (mem_fwd_rd),
    .mem_fwd_data (mem_fwd_data),
    .wb_we        (wb_we),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .ex_in1       (ex_in1),
    .ex_in2       (ex_in2),
    .ex_aluop     (ex_aluop),
    .ex_rd        (ex_rd),
    .ex_reg_write (ex_reg_write),
    .ex_is_branch (ex_is_branch),
    .ex_rs2_val   (ex_rs2_val),
    .ex_illegal   (ex_illegal)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic vld, input logic [3:0] op,
                      input logic [63:0] in1, input logic [63:0] in2,
                      input logic [63:0] rs2v, input logic rw,
                      input logic br, input logic ill,
                      input string tag);
    exp_t e;
    e.vld = vld; e.op = op; e.in1 = in1; e.in2 = in2;
    e.rs2v = rs2v; e.rw = rw; e.br = br; e.ill = ill;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL sb_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    chk({e.tag, "_valid"}, {63'd0, ex_valid}, {63'd0, e.vld});
    chk({e.tag, "_aluop"}, {60'd0, ex_aluop}, {60'd0, e.op});
    chk({e.tag, "_in1"}, ex_in1, e.in1);
    chk({e.tag, "_in2"}, ex_in2, e.in2);
    chk({e.tag, "_rs2v"}, ex_rs2_val, e.rs2v);
    chk({e.tag, "_rw"}, {63'd0, ex_reg_write}, {63'd0, e.rw});
    chk({e.tag, "_br"}, {63'd0, ex_is_branch}, {63'd0, e.br});
    chk({e.tag, "_ill"}, {63'd0, ex_illegal}, {63'd0, e.ill});
  endtask

  task automatic drive(input logic [1:0] cls, input logic [2:0] f3,
                       input logic f7, input logic src, input logic rw,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [63:0] d1,
                       input logic [63:0] d2, input logic [63:0] imm);
    id_valid     = 1'b1;
    id_op_class  = cls;
    id_funct3    = f3;
    id_funct7_5  = f7;
    id_alu_src   = src;
    id_reg_write = rw;
    id_rs1       = rs1;
    id_rs2       = rs2;
    id_rd        = rd;
    id_rs1_data  = d1;
    id_rs2_data  = d2;
    id_imm       = imm;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
    id_valid = 1'b0; id_op_class = 2'b00; id_funct3 = 3'b000;
    id_funct7_5 = 1'b0; id_alu_src = 1'b0; id_reg_write = 1'b0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
    mem_fwd_we = 1'b0; mem_fwd_rd = '0; mem_fwd_data = '0;
    wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    step();
    step();
    rst = 1'b0;
    #1;
    push(1'b0, 4'b0000, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, "reset");
    check_out();
    chk("reset_ready", {63'd0, id_ready}, 64'd1);

    // R-type SUB
    drive(2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3,
          64'd10, 64'd3, 64'd0);
    push(1'b1, 4'b0110, 64'd10, 64'd3, 64'd3, 1'b1, 1'b0, 1'b0, "sub");
    step();
    id_valid = 1'b0;
    check_out();
    chk("sub_ready", {63'd0, id_ready}, 64'd1);

    // forwarding priority MEM over WB, then WB alone
    drive(2'b11, 3'b110, 1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 5'd4,
          64'h11, 64'h22, 64'h40);
    mem_fwd_we = 1'b1; mem_fwd_rd = 5'd5; mem_fwd_data = 64'hAA;
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 64'hBB;
    push(1'b1, 4'b0001, 64'hAA, 64'h40, 64'hAA, 1'b1, 1'b0, 1'b0,
         "fwd_mem");
    step();
    id_valid = 1'b0;
    check_out();
    mem_fwd_we = 1'b0;
    #1;
    chk("fwd_wb_in1", ex_in1, 64'hBB);
    chk("fwd_wb_rs2v", ex_rs2_val, 64'hBB);

    // x0 never forwards
    drive(2'b10, 3'b111, 1'b0, 1'b0, 1'b1, 5'd0, 5'd6, 5'd4,
          64'h99, 64'h22, 64'd0);
    mem_fwd_we = 1'b1; mem_fwd_rd = 5'd0;
    wb_we = 1'b1; wb_rd = 5'd0;
    push(1'b1, 4'b0000, 64'd0, 64'h22, 64'h22, 1'b1, 1'b0, 1'b0,
         "fwd_x0");
    step();
    id_valid = 1'b0;
    check_out();
    mem_fwd_we = 1'b0; wb_we = 1'b0;

    // drain then stall with a held instruction
    step();
    chk("idle_valid", {63'd0, ex_valid}, 64'd0);
    ex_ready = 1'b0;
    drive(2'b10, 3'b111, 1'b0, 1'b0, 1'b1, 5'd1, 5'd7, 5'd8,
          64'd4, 64'h12, 64'd0);
    push(1'b1, 4'b0000, 64'd4, 64'h12, 64'h12, 1'b1, 1'b0, 1'b0,
         "stall_ld");
    step();
    check_out();
    chk("stall_ready0", {63'd0, id_ready}, 64'd0);
    // a new branch waits at ID; it must not be taken
    drive(2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 5'd9, 5'd9, 5'd9,
          64'd1, 64'd2, 64'd3);
    wb_we = 1'b1; wb_rd = 5'd7; wb_data = 64'h55;
    #1;
    chk("stall_fwd_in2", ex_in2, 64'h55);
    step();
    wb_we = 1'b0;
    #1;
    push(1'b1, 4'b0000, 64'd4, 64'h55, 64'h55, 1'b1, 1'b0, 1'b0,
         "stall_hold1");
    check_out();
    chk("stall_ready1", {63'd0, id_ready}, 64'd0);
    step();
    push(1'b1, 4'b0000, 64'd4, 64'h55, 64'h55, 1'b1, 1'b0, 1'b0,
         "stall_hold2");
    check_out();
    chk("stall_ready2", {63'd0, id_ready}, 64'd0);

    // reset mid-stall
    rst = 1'b1;
    id_valid = 1'b0;
    step();
    rst = 1'b0;
    chk("rst_valid", {63'd0, ex_valid}, 64'd0);
    chk("rst_aluop", {60'd0, ex_aluop}, 64'd0);
    chk("rst_in2", ex_in2, 64'd0);
    chk("rst_ready", {63'd0, id_ready}, 64'd1);

    // flush beats a simultaneous load
    ex_ready = 1'b1;
    drive(2'b10, 3'b000, 1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3,
          64'd5, 64'd6, 64'd0);
    push(1'b1, 4'b0010, 64'd5, 64'd6, 64'd6, 1'b1, 1'b0, 1'b0,
         "pre_flush");
    step();
    check_out();
    flush = 1'b1;
    drive(2'b10, 3'b000, 1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3,
          64'd7, 64'd8, 64'd0);
    step();
    flush = 1'b0;
    id_valid = 1'b0;
    chk("flush_valid", {63'd0, ex_valid}, 64'd0);
    chk("flush_rw", {63'd0, ex_reg_write}, 64'd0);

    // decode corners
    drive(2'b10, 3'b001, 1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3,
          64'h100, 64'h200, 64'h8);
    push(1'b1, 4'b0010, 64'h100, 64'h200, 64'h200, 1'b1, 1'b0, 1'b1,
         "illegal");
    step();
    check_out();
    drive(2'b11, 3'b000, 1'b1, 1'b1, 1'b1, 5'd1, 5'd2, 5'd3,
          64'h100, 64'h200, 64'h7);
    push(1'b1, 4'b0010, 64'h100, 64'h7, 64'h200, 1'b1, 1'b0, 1'b0,
         "i_add_f7");
    step();
    check_out();
    drive(2'b01, 3'b101, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0,
          64'h100, 64'h200, 64'h8);
    push(1'b1, 4'b0110, 64'h100, 64'h200, 64'h200, 1'b0, 1'b1, 1'b0,
         "branch");
    step();
    check_out();
    drive(2'b10, 3'b010, 1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3,
          64'h100, 64'h200, 64'h8);
    push(1'b1, 4'b0111, 64'h100, 64'h200, 64'h200, 1'b1, 1'b0, 1'b0,
         "slt");
    step();
    check_out();
    drive(2'b00, 3'b011, 1'b0, 1'b1, 1'b1, 5'd1, 5'd2, 5'd3,
          64'h100, 64'h200, 64'h8);
    push(1'b1, 4'b0010, 64'h100, 64'h8, 64'h200, 1'b1, 1'b0, 1'b0,
         "load");
    step();
    check_out();
    id_valid = 1'b0;
    step();
    chk("drain_valid", {63'd0, ex_valid}, 64'd0);
    chk("sb_left", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
